// File: rtl/gpio_arbiter.sv
// Two-master round-robin arbiter in front of a single registered-handshake slave.
// One transaction at a time: IDLE grants, BUSY waits for slave ready (or timeout),
// TURN absorbs the slave's stale ready before the next grant.
module gpio_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clock,
  input  logic        i_reset,
  // master 0
  input  logic        i_m0_request,
  input  logic        i_m0_rw,
  input  logic [31:0] i_m0_address,
  input  logic [31:0] i_m0_wdata,
  output logic [31:0] o_m0_rdata,
  output logic        o_m0_ready,
  // master 1
  input  logic        i_m1_request,
  input  logic        i_m1_rw,
  input  logic [31:0] i_m1_address,
  input  logic [31:0] i_m1_wdata,
  output logic [31:0] o_m1_rdata,
  output logic        o_m1_ready,
  // slave
  output logic        o_s_request,
  output logic        o_s_rw,
  output logic [31:0] o_s_address,
  output logic [31:0] o_s_wdata,
  input  logic [31:0] i_s_rdata,
  input  logic        i_s_ready,
  output logic        o_timeout
);

  // Keep at least one bit so TIMEOUT = 0 still elaborates cleanly.
  localparam int unsigned CntW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StBusy, StTurn} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;      // master granted most recently (1 = master 1)
  logic        gnt_q, gnt_d;        // master owning the current transaction
  logic [CntW-1:0] cnt_q, cnt_d;
  logic        s_req_q, s_req_d;
  logic        s_rw_q, s_rw_d;
  logic [31:0] s_addr_q, s_addr_d;
  logic [31:0] s_wdata_q, s_wdata_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;
  logic        m0_ready_q, m0_ready_d;
  logic        m1_ready_q, m1_ready_d;
  logic        timeout_q, timeout_d;

  logic        grant_m1;
  logic        done;
  logic [31:0] done_rdata;

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= StIdle;
      last_q     <= 1'b1;
      gnt_q      <= 1'b0;
      cnt_q      <= '0;
      s_req_q    <= 1'b0;
      s_rw_q     <= 1'b0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      cnt_q      <= cnt_d;
      s_req_q    <= s_req_d;
      s_rw_q     <= s_rw_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      m0_ready_q <= m0_ready_d;
      m1_ready_q <= m1_ready_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state: grant in IDLE, complete in BUSY, drain stale ready in TURN.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    s_req_d    = s_req_q;
    s_rw_d     = s_rw_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    m0_ready_d = 1'b0;
    m1_ready_d = 1'b0;
    timeout_d  = 1'b0;
    done       = 1'b0;
    done_rdata = i_s_rdata;
    // On a tie the master not granted last wins.
    grant_m1   = (i_m0_request && i_m1_request) ? ~last_q : i_m1_request;

    case (state_q)
      StIdle: begin
        if (i_m0_request || i_m1_request) begin
          gnt_d     = grant_m1;
          last_d    = grant_m1;
          cnt_d     = '0;
          s_req_d   = 1'b1;
          s_rw_d    = grant_m1 ? i_m1_rw      : i_m0_rw;
          s_addr_d  = grant_m1 ? i_m1_address : i_m0_address;
          s_wdata_d = grant_m1 ? i_m1_wdata   : i_m0_wdata;
          state_d   = StBusy;
        end
      end
      StBusy: begin
        if (i_s_ready) begin
          // Ready beats a coinciding timeout.
          done       = 1'b1;
          done_rdata = i_s_rdata;
        end else if ((TIMEOUT != 0) && (cnt_q == CntLimit)) begin
          done       = 1'b1;
          done_rdata = 32'hFFFF_FFFF;
          timeout_d  = 1'b1;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (done) begin
          s_req_d = 1'b0;
          if (gnt_q) begin
            m1_rdata_d = done_rdata;
            m1_ready_d = 1'b1;
          end else begin
            m0_rdata_d = done_rdata;
            m0_ready_d = 1'b1;
          end
          state_d = StTurn;
        end
      end
      StTurn: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign o_s_request = s_req_q;
  assign o_s_rw      = s_rw_q;
  assign o_s_address = s_addr_q;
  assign o_s_wdata   = s_wdata_q;
  assign o_m0_rdata  = m0_rdata_q;
  assign o_m1_rdata  = m1_rdata_q;
  assign o_m0_ready  = m0_ready_q;
  assign o_m1_ready  = m1_ready_q;
  assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_gpio_arbiter.sv
// Directed bench for gpio_arbiter: queued master jobs, a registered-ready slave model
// and a scoreboard of expected completions popped on each ready pulse.
module tb_gpio_arbiter;

  localparam int unsigned To = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_rw = 1'b0, m1_req = 1'b0, m1_rw = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m1_ready;
  logic        s_request, s_rw, s_ready, timeout;
  logic [31:0] s_address, s_wdata, s_rdata;

  gpio_arbiter #(.TIMEOUT(To)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_m0_request (m0_req),
    .i_m0_rw      (m0_rw),
    .i_m0_address (m0_addr),
    .i_m0_wdata   (m0_wdata),
    .o_m0_rdata   (m0_rdata),
    .o_m0_ready   (m0_ready),
    .i_m1_request (m1_req),
    .i_m1_rw      (m1_rw),
    .i_m1_address (m1_addr),
    .i_m1_wdata   (m1_wdata),
    .o_m1_rdata   (m1_rdata),
    .o_m1_ready   (m1_ready),
    .o_s_request  (s_request),
    .o_s_rw       (s_rw),
    .o_s_address  (s_address),
    .o_s_wdata    (s_wdata),
    .i_s_rdata    (s_rdata),
    .i_s_ready    (s_ready),
    .o_timeout    (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Slave: ready once request has been seen for slave_delay cycles (0 = never).
  int slave_delay = 1;
  int sc;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sc      <= 0;
      s_ready <= 1'b0;
    end else begin
      sc      <= s_request ? sc + 1 : 0;
      s_ready <= s_request && (slave_delay != 0) && (sc >= slave_delay - 1);
    end
  end
  assign s_rdata = s_address + 32'h56;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
  } job_t;

  typedef struct {
    int unsigned m;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        to;
  } exp_t;

  job_t m0_jobs[$];
  job_t m1_jobs[$];
  exp_t sb[$];

  logic        m0_alt_en = 1'b0;
  logic [31:0] m0_alt = '0;

  task automatic push(input int unsigned m, input logic rw, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic to);
    job_t j;
    exp_t e;
    j.rw = rw; j.addr = addr; j.wdata = wdata;
    e.m = m; e.rw = rw; e.addr = addr; e.wdata = wdata; e.to = to;
    e.rdata = to ? 32'hFFFF_FFFF : addr + 32'h56;
    if (m == 0) m0_jobs.push_back(j);
    else m1_jobs.push_back(j);
    sb.push_back(e);
  endtask

  // Monitor + master drivers, all on the falling edge.
  logic [31:0] exp_rd0 = '0, exp_rd1 = '0;
  logic        exp_to;
  logic        prev_req = 1'b0;
  int          low_run = 2;
  exp_t        e_cur;

  always @(negedge clk) begin
    if (rst) begin
      m0_jobs.delete();
      m1_jobs.delete();
      sb.delete();
      exp_rd0  = '0;
      exp_rd1  = '0;
      prev_req = 1'b0;
      low_run  = 2;
    end else begin
      exp_to = 1'b0;
      if (s_request) begin
        check_bit("s_req_expected", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          check_bit("s_rw", s_rw, sb[0].rw);
          check_eq("s_address", s_address, sb[0].addr);
          check_eq("s_wdata", s_wdata, sb[0].wdata);
        end
        if (!prev_req) check_bit("s_req_gap", low_run >= 2, 1'b1);
        low_run = 0;
      end else begin
        low_run++;
      end
      prev_req = s_request;
      check_bit("ready_overlap", m0_ready & m1_ready, 1'b0);
      if (m0_ready || m1_ready) begin
        check_bit("ready_expected", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          e_cur = sb.pop_front();
          check_eq("ready_master", {31'b0, m1_ready}, e_cur.m);
          if (e_cur.m == 0) exp_rd0 = e_cur.rdata;
          else exp_rd1 = e_cur.rdata;
          exp_to = e_cur.to;
        end
      end
      check_bit("timeout", timeout, exp_to);
      check_eq("m0_rdata", m0_rdata, exp_rd0);
      check_eq("m1_rdata", m1_rdata, exp_rd1);
      if (m0_ready && m0_jobs.size() > 0) void'(m0_jobs.pop_front());
      if (m1_ready && m1_jobs.size() > 0) void'(m1_jobs.pop_front());
    end
    m0_req   = m0_jobs.size() > 0;
    m0_rw    = m0_req ? m0_jobs[0].rw : 1'b0;
    m0_addr  = m0_req ? (m0_alt_en ? m0_alt : m0_jobs[0].addr) : '0;
    m0_wdata = m0_req ? m0_jobs[0].wdata : '0;
    m1_req   = m1_jobs.size() > 0;
    m1_rw    = m1_req ? m1_jobs[0].rw : 1'b0;
    m1_addr  = m1_req ? m1_jobs[0].addr : '0;
    m1_wdata = m1_req ? m1_jobs[0].wdata : '0;
  end

  task automatic wait_done(input int budget);
    int n = 0;
    while ((sb.size() != 0 || m0_jobs.size() != 0 || m1_jobs.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_bit("wait_done", n < budget, 1'b1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic cyc_chk(input string tag, input logic req, input logic r0, input logic r1);
    @(negedge clk);
    check_bit({tag, "_s_req"}, s_request, req);
    check_bit({tag, "_m0_ready"}, m0_ready, r0);
    check_bit({tag, "_m1_ready"}, m1_ready, r1);
  endtask

  task automatic check_all_zero(input string tag);
    check_bit({tag, "_s_req"}, s_request, 1'b0);
    check_bit({tag, "_s_rw"}, s_rw, 1'b0);
    check_eq({tag, "_s_addr"}, s_address, 32'h0);
    check_eq({tag, "_s_wdata"}, s_wdata, 32'h0);
    check_bit({tag, "_m0_ready"}, m0_ready, 1'b0);
    check_bit({tag, "_m1_ready"}, m1_ready, 1'b0);
    check_eq({tag, "_m0_rdata"}, m0_rdata, 32'h0);
    check_eq({tag, "_m1_rdata"}, m1_rdata, 32'h0);
    check_bit({tag, "_timeout"}, timeout, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    // Simultaneous continuous requests alternate, M0 first
    for (int i = 0; i < 4; i++) begin
      push(0, i[0], 32'h100 + 32'(i) * 4, 32'hA0 + 32'(i), 1'b0);
      push(1, ~i[0], 32'h200 + 32'(i) * 4, 32'hB0 + 32'(i), 1'b0);
    end
    wait_done(200);

    // Single M0 read, cycle-exact latency
    slave_delay = 1;
    push(0, 1'b0, 32'h4, 32'h0, 1'b0);
    cyc_chk("lat_c0", 1'b0, 1'b0, 1'b0);
    cyc_chk("lat_c1", 1'b1, 1'b0, 1'b0);
    cyc_chk("lat_c2", 1'b1, 1'b0, 1'b0);
    cyc_chk("lat_c3", 1'b0, 1'b1, 1'b0);
    check_eq("lat_m0_rdata", m0_rdata, 32'h0000_005A);
    cyc_chk("lat_c4", 1'b0, 1'b0, 1'b0);
    wait_done(50);

    // M1 write; slave ready stays high into TURN
    push(1, 1'b1, 32'h0, 32'h3, 1'b0);
    wait_done(50);

    // Address change during BUSY is ignored
    slave_delay = 3;
    push(0, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    m0_alt    = 32'h4;
    m0_alt_en = 1'b1;
    wait_done(50);
    m0_alt_en = 1'b0;

    // Ready arrives on the last timeout cycle: ready wins
    slave_delay = 3;
    push(1, 1'b0, 32'h20, 32'h0, 1'b0);
    wait_done(50);

    // Silent slave: forced completion after TIMEOUT cycles
    slave_delay = 0;
    push(0, 1'b0, 32'h10, 32'h0, 1'b1);
    cyc_chk("to_c0", 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) cyc_chk("to_busy", 1'b1, 1'b0, 1'b0);
    cyc_chk("to_c5", 1'b0, 1'b1, 1'b0);
    check_bit("to_c5_pulse", timeout, 1'b1);
    check_eq("to_c5_rdata", m0_rdata, 32'hFFFF_FFFF);
    cyc_chk("to_c6", 1'b0, 1'b0, 1'b0);
    check_bit("to_c6_pulse", timeout, 1'b0);
    wait_done(50);

    // M0 withdraws its request while M1 holds the bus
    slave_delay = 0;
    push(1, 1'b0, 32'h30, 32'h0, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    m0_jobs.push_back('{rw: 1'b0, addr: 32'h34, wdata: 32'h0});
    @(posedge clk);
    #2;
    m0_jobs.delete();
    wait_done(50);

    // Reset in the middle of an M0 write
    slave_delay = 3;
    push(0, 1'b1, 32'h8, 32'hDEAD_BEEF, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    slave_delay = 1;
    push(0, 1'b0, 32'h44, 32'h0, 1'b0);
    push(1, 1'b0, 32'h48, 32'h0, 1'b0);
    wait_done(100);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1);
  end

endmodule
